loop_gain_scheduler: RTL and testbench
======================================

# loop_gain_scheduler

Gear-shifting gain controller for the ADPLL PI loop filter. Watches the signed phase error and steps the filter through acquisition, tracking and locked gain sets once the error stays within a window for a programmed dwell. Drives the filter's dynamic `kp`/`ki` inputs and its reset, and reports lock status to the top level.

## Interface
- `ERROR_WIDTH`, 5, width of the signed phase error.
- `KP_WIDTH`, 5, width of the `kp_o` gain.
- `KI_WIDTH`, 7, width of the `ki_o` gain.
- `KP_ACQ` / `KI_ACQ`, 8 / 16, acquisition-stage gains.
- `KP_TRK` / `KI_TRK`, 4 / 4, tracking-stage gains.
- `KP_LCK` / `KI_LCK`, 1 / 1, locked-stage gains.
- `LOCK_THRESH`, 2, an error magnitude ≤ this is in-window.
- `DWELL_COUNT`, 64, number of consecutive in-window samples needed to advance one stage (≥1).
- `UNLOCK_THRESH`, 6, an error magnitude > this is a gross error. Must be ≥ `LOCK_THRESH`.
- `UNLOCK_COUNT`, 4, number of consecutive gross-error samples that force re-acquisition (≥1).
- `CNT_WIDTH`, 8, counter width. Must hold `DWELL_COUNT` and `UNLOCK_COUNT`.
- Reset `reset_i`: asynchronous, active-high. Clock `gen_clk_i`.
- `gen_clk_i`  in  1  loop clock, shared with the filter.
- `reset_i`  in  1  asynchronous reset, active-high.
- `enable_i`  in  1  run request; low returns the block to IDLE.
- `error_i`  in  ERROR_WIDTH  signed phase error (same sample the filter sees).
- `kp_o`  out  KP_WIDTH  proportional gain to the filter.
- `ki_o`  out  KI_WIDTH  integral gain to the filter.
- `filter_rst_o`  out  1  holds the filter (including its integrator) in reset.
- `stage_o`  out  2  current stage: 0 IDLE, 1 ACQ, 2 TRK, 3 LCK.
- `locked_o`  out  1  high while in LCK.
- `gain_change_o`  out  1  one-cycle pulse on every gain update.
- `lost_lock_o`  out  1  one-cycle pulse on an LCK→ACQ fall-back.

## Operation
- **Magnitude:** |error_i| is computed with ERROR_WIDTH+1 bits. The most-negative code therefore has magnitude 2^(ERROR_WIDTH-1), which is never in-window.
- **States and transitions:**
  - IDLE → ACQ when `enable_i` is high.
  - ACQ → TRK and TRK → LCK after `DWELL_COUNT` consecutive in-window samples.
  - LCK holds.
- **Disable:** `enable_i` low forces IDLE from any state on the next edge. This has priority over every other transition.
- **Dwell counter:**
  - Increments on each in-window sample.
  - Clears on any out-of-window sample and on every state change.
  - Held at 0 in IDLE and LCK.
- **Gains by stage:** IDLE and ACQ use `*_ACQ`, TRK uses `*_TRK`, LCK uses `*_LCK`.
- **Filter reset:** `filter_rst_o` = 1 in IDLE only.
- **Gain-change pulse:** `gain_change_o` pulses on ACQ→TRK, TRK→LCK and LCK→ACQ. It does not pulse on IDLE↔ACQ.
- **Reset values:**
  - `stage_o` = 0, `kp_o` = `KP_ACQ`, `ki_o` = `KI_ACQ`, `filter_rst_o` = 1.
  - `locked_o`, `gain_change_o` and `lost_lock_o` = 0.
  - All counters 0.
- **Reset mid-operation:** state and counters return to reset values immediately, with no pulse emitted.

## Timing
- All outputs are registered.
- The transition decision is combinational from `error_i` and the counter, and is registered on the rising edge of `gen_clk_i`.
- If `error_i` is in-window at `DWELL_COUNT` consecutive edges, `stage_o`, `kp_o` and `ki_o` update at the last of those edges.
- `gain_change_o` and `lost_lock_o` are high for exactly the cycle following that edge, aligned with the new gains.
- `enable_i` rising: `stage_o` = 1 and `filter_rst_o` = 0 after one edge.
- In-window and gross error are mutually exclusive because `UNLOCK_THRESH` ≥ `LOCK_THRESH`.

## Configuration
- Macro `LOOP_GAIN_SCHED_UNLOCK_EN`.
- **Defined:** in LCK, `UNLOCK_COUNT` consecutive gross-error samples cause LCK→ACQ on the last of those edges.
  - Gains revert to `*_ACQ` and the filter is not reset.
  - `gain_change_o` and `lost_lock_o` pulse.
  - The unlock counter clears on any non-gross sample and on any state change.
- **Undefined:** LCK is left only by `enable_i` low or reset. `lost_lock_o` is tied 0 and no unlock counter is built.

## Structure
- **Package `loop_ctrl_pkg`:** stage encoding constants (IDLE/ACQ/TRK/LCK) and the 2-bit stage width, shared with the top level and status logic.
- **Sub-module `run_length_counter`:** counts consecutive asserted samples up to a target and flags on the target sample, with synchronous clear. Instantiated for the dwell count and, under the macro, for the unlock count.

## Test plan
- **Reset and enable:** reset, then `enable_i` = 1 → one edge later `stage_o` = 1, `filter_rst_o` = 0, `kp_o` = 8, `ki_o` = 16.
- **Dwell sequence:** error = 1 for 64 edges → TRK with `gain_change_o` pulse. 64 more in-window edges → LCK with `locked_o` = 1, `kp_o` = 1, `ki_o` = 1.
- **Dwell restart and magnitude corner:**
  - In ACQ, 63 in-window samples, then error = 3, then 63 in-window → still ACQ; one more in-window sample → TRK.
  - error = −16 (most-negative code) is never in-window.
- **Disable priority:** `enable_i` low on the same edge the dwell completes → IDLE, `filter_rst_o` = 1, gains = ACQ values, no `gain_change_o` pulse.
- **Unlock (macro on):** in LCK, error = 7 for 4 edges → ACQ with `lost_lock_o` and `gain_change_o` pulses. error = 7, 7, 7, 0 → stays LCK.
- **Unlock absent (macro off):** in LCK, error = 15 for 100 edges → stays LCK, `lost_lock_o` = 0.

Source files
------------

// File: rtl/loop_ctrl_pkg.sv
// Shared stage encoding for the ADPLL loop gain scheduler and the
// status logic that reads stage_o at the top level.
package loop_ctrl_pkg;

    localparam int STAGE_W = 2;

    localparam logic [STAGE_W-1:0] STG_IDLE = 2'd0;
    localparam logic [STAGE_W-1:0] STG_ACQ  = 2'd1;
    localparam logic [STAGE_W-1:0] STG_TRK  = 2'd2;
    localparam logic [STAGE_W-1:0] STG_LCK  = 2'd3;

endpackage

// File: rtl/run_length_counter.sv
// run_length_counter: counts consecutive asserted samples and flags the
// sample that completes a run of TARGET.
//   gen_clk_i  in  clock
//   reset_i    in  asynchronous reset, active-high
//   clear_i    in  synchronous clear, wins over sample_i
//   sample_i   in  qualifying sample this cycle
//   hit_o      out combinational: this sample completes the run
// A deasserted sample restarts the run at zero.
module run_length_counter #(
    parameter int CNT_WIDTH = 8,
    parameter int TARGET    = 64
) (
    input  logic gen_clk_i,
    input  logic reset_i,
    input  logic clear_i,
    input  logic sample_i,
    output logic hit_o
);

    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(TARGET - 1);

    logic [CNT_WIDTH-1:0] count_q;

    assign hit_o = sample_i && (count_q == LAST);

    always_ff @(posedge gen_clk_i or posedge reset_i) begin
        if (reset_i)       count_q <= '0;
        else if (clear_i)  count_q <= '0;
        else if (sample_i) count_q <= count_q + CNT_WIDTH'(1);
        else               count_q <= '0;
    end

endmodule

// File: rtl/loop_gain_scheduler.sv
// loop_gain_scheduler: gear-shifting gain controller for the ADPLL PI
// loop filter. Steps IDLE -> ACQ -> TRK -> LCK once the phase error has
// stayed in-window for DWELL_COUNT consecutive samples per stage.
// Optional feature macro: LOOP_GAIN_SCHED_UNLOCK_EN -- when defined,
// UNLOCK_COUNT consecutive gross errors in LCK fall back to ACQ.
//   gen_clk_i      in  loop clock
//   reset_i        in  asynchronous reset, active-high
//   enable_i       in  run request; low returns to IDLE
//   error_i        in  signed phase error
//   kp_o / ki_o    out filter gains for the current stage
//   filter_rst_o   out holds the filter in reset (IDLE only)
//   stage_o        out 0 IDLE, 1 ACQ, 2 TRK, 3 LCK
//   locked_o       out high in LCK
//   gain_change_o  out pulse on ACQ->TRK, TRK->LCK, LCK->ACQ
//   lost_lock_o    out pulse on LCK->ACQ
// All outputs are registered from the next-stage decision.
module loop_gain_scheduler
    import loop_ctrl_pkg::*;
#(
    parameter int ERROR_WIDTH   = 5,
    parameter int KP_WIDTH      = 5,
    parameter int KI_WIDTH      = 7,
    parameter int KP_ACQ        = 8,
    parameter int KI_ACQ        = 16,
    parameter int KP_TRK        = 4,
    parameter int KI_TRK        = 4,
    parameter int KP_LCK        = 1,
    parameter int KI_LCK        = 1,
    parameter int LOCK_THRESH   = 2,
    parameter int DWELL_COUNT   = 64,
    parameter int UNLOCK_THRESH = 6,
    parameter int UNLOCK_COUNT  = 4,
    parameter int CNT_WIDTH     = 8
) (
    input  logic                   gen_clk_i,
    input  logic                   reset_i,
    input  logic                   enable_i,
    input  logic [ERROR_WIDTH-1:0] error_i,
    output logic [KP_WIDTH-1:0]    kp_o,
    output logic [KI_WIDTH-1:0]    ki_o,
    output logic                   filter_rst_o,
    output logic [STAGE_W-1:0]     stage_o,
    output logic                   locked_o,
    output logic                   gain_change_o,
    output logic                   lost_lock_o
);

    localparam int MAG_W = ERROR_WIDTH + 1;

    // Elaboration-time sanity of the configuration.
    if (DWELL_COUNT < 1 || UNLOCK_COUNT < 1 || UNLOCK_THRESH < LOCK_THRESH ||
        DWELL_COUNT > (1 << CNT_WIDTH) || UNLOCK_COUNT > (1 << CNT_WIDTH)) begin : g_bad_cfg
        $error("loop_gain_scheduler: inconsistent threshold/count parameters");
    end

    // One extra bit so the most-negative code has a representable magnitude
    // (2^(ERROR_WIDTH-1)), which then simply fails the window compare.
    logic [MAG_W-1:0] err_ext;
    logic [MAG_W-1:0] err_mag;
    logic             in_window;

    assign err_ext   = {error_i[ERROR_WIDTH-1], error_i};
    assign err_mag   = err_ext[MAG_W-1] ? (~err_ext + MAG_W'(1)) : err_ext;
    assign in_window = (err_mag <= MAG_W'(LOCK_THRESH));

    logic [STAGE_W-1:0] stage_q;
    logic [STAGE_W-1:0] stage_nx;
    logic               dwell_hit;
    logic               unlock_hit;
    logic               stage_chg;

    assign stage_chg = (stage_nx != stage_q);

    // Dwell runs only count in ACQ/TRK; in IDLE/LCK the counter is held clear.
    run_length_counter #(
        .CNT_WIDTH (CNT_WIDTH),
        .TARGET    (DWELL_COUNT)
    ) u_dwell (
        .gen_clk_i (gen_clk_i),
        .reset_i   (reset_i),
        .clear_i   (stage_chg || !(stage_q == STG_ACQ || stage_q == STG_TRK)),
        .sample_i  (in_window),
        .hit_o     (dwell_hit)
    );

`ifdef LOOP_GAIN_SCHED_UNLOCK_EN
    logic gross_err;
    assign gross_err = (err_mag > MAG_W'(UNLOCK_THRESH));

    run_length_counter #(
        .CNT_WIDTH (CNT_WIDTH),
        .TARGET    (UNLOCK_COUNT)
    ) u_unlock (
        .gen_clk_i (gen_clk_i),
        .reset_i   (reset_i),
        .clear_i   (stage_chg || (stage_q != STG_LCK)),
        .sample_i  (gross_err),
        .hit_o     (unlock_hit)
    );
`else
    assign unlock_hit = 1'b0;
`endif

    // Disable outranks every other transition.
    always_comb begin
        stage_nx = stage_q;
        if (!enable_i) begin
            stage_nx = STG_IDLE;
        end else begin
            case (stage_q)
                STG_IDLE: stage_nx = STG_ACQ;
                STG_ACQ:  if (dwell_hit)  stage_nx = STG_TRK;
                STG_TRK:  if (dwell_hit)  stage_nx = STG_LCK;
                STG_LCK:  if (unlock_hit) stage_nx = STG_ACQ;
                default:  stage_nx = STG_IDLE;
            endcase
        end
    end

    logic [KP_WIDTH-1:0] kp_nx;
    logic [KI_WIDTH-1:0] ki_nx;

    always_comb begin
        kp_nx = KP_WIDTH'(KP_ACQ);
        ki_nx = KI_WIDTH'(KI_ACQ);
        case (stage_nx)
            STG_TRK: begin kp_nx = KP_WIDTH'(KP_TRK); ki_nx = KI_WIDTH'(KI_TRK); end
            STG_LCK: begin kp_nx = KP_WIDTH'(KP_LCK); ki_nx = KI_WIDTH'(KI_LCK); end
            default: ;
        endcase
    end

    logic fall_back;
    assign fall_back = (stage_q == STG_LCK) && (stage_nx == STG_ACQ);

    always_ff @(posedge gen_clk_i or posedge reset_i) begin
        if (reset_i) begin
            stage_q       <= STG_IDLE;
            kp_o          <= KP_WIDTH'(KP_ACQ);
            ki_o          <= KI_WIDTH'(KI_ACQ);
            filter_rst_o  <= 1'b1;
            locked_o      <= 1'b0;
            gain_change_o <= 1'b0;
        end else begin
            stage_q       <= stage_nx;
            kp_o          <= kp_nx;
            ki_o          <= ki_nx;
            filter_rst_o  <= (stage_nx == STG_IDLE);
            locked_o      <= (stage_nx == STG_LCK);
            gain_change_o <= ((stage_q == STG_ACQ) && (stage_nx == STG_TRK)) ||
                             ((stage_q == STG_TRK) && (stage_nx == STG_LCK)) ||
                             fall_back;
        end
    end

`ifdef LOOP_GAIN_SCHED_UNLOCK_EN
    always_ff @(posedge gen_clk_i or posedge reset_i) begin
        if (reset_i) lost_lock_o <= 1'b0;
        else         lost_lock_o <= fall_back;
    end
`else
    assign lost_lock_o = 1'b0;
`endif

    assign stage_o = stage_q;

endmodule

// File: tb/tb_loop_gain_scheduler.sv
// Scoreboard bench for loop_gain_scheduler: the stimulus side advances a
// stage-level reference model and queues the expected outputs; a monitor
// on the falling edge pops and compares against the DUT.
module tb_loop_gain_scheduler;

    typedef struct packed {
        logic [1:0] stage;
        logic [4:0] kp;
        logic [6:0] ki;
        logic       frst;
        logic       locked;
        logic       gc;
        logic       ll;
    } exp_t;

    logic             gen_clk_i = 1'b0;
    logic             reset_i   = 1'b1;
    logic             enable_i  = 1'b0;
    logic [4:0]       error_i   = '0;
    logic [4:0]       kp_o;
    logic [6:0]       ki_o;
    logic             filter_rst_o;
    logic [1:0]       stage_o;
    logic             locked_o;
    logic             gain_change_o;
    logic             lost_lock_o;

    loop_gain_scheduler dut (
        .gen_clk_i     (gen_clk_i),
        .reset_i       (reset_i),
        .enable_i      (enable_i),
        .error_i       (error_i),
        .kp_o          (kp_o),
        .ki_o          (ki_o),
        .filter_rst_o  (filter_rst_o),
        .stage_o       (stage_o),
        .locked_o      (locked_o),
        .gain_change_o (gain_change_o),
        .lost_lock_o   (lost_lock_o)
    );

    always #5 gen_clk_i = ~gen_clk_i;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    // Reference model: stage 0..3 plus lengths of the current in-window and
    // gross-error runs within the present stage.
    int m_stage = 0;
    int m_run   = 0;
    int m_gross = 0;
    exp_t m_out;

    function automatic exp_t outputs_for(int stg, bit gc, bit ll);
        exp_t e;
        e.stage  = 2'(stg);
        e.kp     = (stg == 2) ? 5'd4 : (stg == 3) ? 5'd1 : 5'd8;
        e.ki     = (stg == 2) ? 7'd4 : (stg == 3) ? 7'd1 : 7'd16;
        e.frst   = (stg == 0);
        e.locked = (stg == 3);
        e.gc     = gc;
        e.ll     = ll;
        return e;
    endfunction

    task automatic model_reset();
        m_stage = 0; m_run = 0; m_gross = 0;
        m_out = outputs_for(0, 1'b0, 1'b0);
    endtask

    task automatic model_edge(bit en, int err);
        int  mag, nxt;
        bit  inw, gross, unlock_en;
        mag   = (err < 0) ? -err : err;
        inw   = (mag <= 2);
        gross = (mag > 6);
`ifdef LOOP_GAIN_SCHED_UNLOCK_EN
        unlock_en = 1'b1;
`else
        unlock_en = 1'b0;
`endif
        nxt = m_stage;
        if (!en) nxt = 0;
        else if (m_stage == 0) nxt = 1;
        else if ((m_stage == 1 || m_stage == 2) && inw && m_run + 1 == 64) nxt = m_stage + 1;
        else if (m_stage == 3 && unlock_en && gross && m_gross + 1 == 4) nxt = 1;

        if (nxt != m_stage) begin
            m_run = 0; m_gross = 0;
        end else begin
            m_run   = (inw && (m_stage == 1 || m_stage == 2)) ? m_run + 1 : 0;
            m_gross = (gross && m_stage == 3) ? m_gross + 1 : 0;
        end
        m_out = outputs_for(nxt,
                            (m_stage == 1 && nxt == 2) || (m_stage == 2 && nxt == 3) ||
                            (m_stage == 3 && nxt == 1),
                            m_stage == 3 && nxt == 1);
        m_stage = nxt;
    endtask

    // One clock of stimulus; expectation is queued at the edge and popped
    // by the monitor at the following falling edge.
    task automatic step(bit en, int err);
        enable_i = en;
        error_i  = 5'(err);
        @(posedge gen_clk_i);
        model_edge(en, err);
        sb_q.push_back(m_out);
        #2;
    endtask

    task automatic do_reset(int n);
        @(negedge gen_clk_i);
        #1;
        reset_i = 1'b1;
        model_reset();
        for (int i = 0; i < n; i++) begin
            sb_q.push_back(m_out);
            @(negedge gen_clk_i);
            #1;
        end
        reset_i = 1'b0;
    endtask

    always @(negedge gen_clk_i) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            exp_t a;
            e = sb_q.pop_front();
            a = {stage_o, kp_o, ki_o, filter_rst_o, locked_o, gain_change_o, lost_lock_o};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL outputs at %0t: got stage=%0d kp=%0d ki=%0d frst=%b lck=%b gc=%b ll=%b, expected stage=%0d kp=%0d ki=%0d frst=%b lck=%b gc=%b ll=%b",
                         $time, a.stage, a.kp, a.ki, a.frst, a.locked, a.gc, a.ll,
                         e.stage, e.kp, e.ki, e.frst, e.locked, e.gc, e.ll);
            end
        end
    end

    initial begin
        do_reset(3);

        // Enable, then two full dwells up to LCK.
        step(1, 0);
        for (int i = 0; i < 64; i++) step(1, 1);
        for (int i = 0; i < 64; i++) step(1, -2);

        // Gross errors in LCK: 7,7,7,0 never completes a run; then four 7s.
        step(1, 7); step(1, 7); step(1, 7); step(1, 0);
        for (int i = 0; i < 4; i++) step(1, 7);
        // Large errors for a long stretch (stays in LCK when unlock is absent).
        for (int i = 0; i < 100; i++) step(1, 15);

        // Dwell restart: 63 in, one out-of-window, 63 in (still ACQ), one more.
        step(0, 0);
        step(1, 0);
        for (int i = 0; i < 63; i++) step(1, 2);
        step(1, 3);
        for (int i = 0; i < 63; i++) step(1, -1);
        step(1, 0);

        // Most-negative code breaks the run in TRK.
        for (int i = 0; i < 63; i++) step(1, 0);
        step(1, -16);
        for (int i = 0; i < 63; i++) step(1, 1);

        // Disable on the very edge that would complete the dwell.
        step(0, 1);
        step(1, 0);
        for (int i = 0; i < 63; i++) step(1, 0);
        step(0, 0);
        step(0, 0);

        // Reset in the middle of a run, then resume.
        step(1, 0);
        for (int i = 0; i < 70; i++) step(1, 1);
        do_reset(2);
        step(1, 0);
        step(1, 1);

        // Random operation, mostly in-window with occasional disables.
        for (int i = 0; i < 4000; i++) begin
            int r;
            int err;
            bit en;
            en  = ($urandom_range(0, 499) != 0);
            r   = int'($urandom_range(0, 99));
            err = (r < 96) ? int'($urandom_range(0, 4)) - 2 : int'($urandom_range(0, 31)) - 16;
            step(en, err);
        end

        @(negedge gen_clk_i);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d left, 0 expected", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
